merger_out_serializer: RTL and testbench

//  Downstream of the 16-wide merger. Accepts sorted 16-element tuples over the

---
 rtl/merger_out_serializer_if.sv | 45 ++++
 rtl/merger_out_serializer.sv | 175 +++++++++++++++++
 tb/tb_merger_out_serializer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/merger_out_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : merger_out_serializer_if
// Description : Bundles the merger-side write port and the beat-side
//               valid/ready stream of merger_out_serializer.
//               slave  : serializer view (accepts tuples, drives beats)
//               master : environment view (pushes tuples, consumes beats)
//               Signals:
//                 i_data     16*DATA_WIDTH  tuple from merger
//                 i_write    1              push i_data this cycle
//                 o_ready    1              buffer has headroom
//                 o_data     OUT_ELEMS*DATA_WIDTH output beat
//                 o_valid    1              beat valid
//                 i_ready    1              consumer accepts beat
//                 o_last     1              beat is a run terminator
//                 o_run_len  RUN_W          data tuples in finished run
//                 o_overflow 1              sticky write-dropped flag
// Revision    : 1.0 - initial release
// ============================================================================
interface merger_out_serializer_if #(
    parameter int DATA_WIDTH = 80,
    parameter int OUT_ELEMS  = 4,
    parameter int RUN_W      = 32
);
    logic [16*DATA_WIDTH-1:0]        i_data;
    logic                            i_write;
    logic                            o_ready;
    logic [OUT_ELEMS*DATA_WIDTH-1:0] o_data;
    logic                            o_valid;
    logic                            i_ready;
    logic                            o_last;
    logic [RUN_W-1:0]                o_run_len;
    logic                            o_overflow;

    modport slave (
        input  i_data, i_write, i_ready,
        output o_ready, o_data, o_valid, o_last, o_run_len, o_overflow
    );

    modport master (
        output i_data, i_write, i_ready,
        input  o_ready, o_data, o_valid, o_last, o_run_len, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/merger_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : merger_out_serializer
// Description : Buffers sorted 16-element tuples written by the merger and
//               serializes each into OUT_ELEMS-wide beats on a valid/ready
//               stream. A tuple whose element 0 is zero is a run terminator:
//               it is sent as a single beat with o_last=1 and the number of
//               data tuples in the run on o_run_len.
//               Ports:
//                 i_clk  clock, all state on rising edge
//                 i_rst  asynchronous reset, active-high
//                 bus    merger_out_serializer_if.slave (see interface)
//                 o_tuples_total / o_runs_total (MERGER_OUT_STATS_EN only)
//                        wrapping 32-bit counts of popped data tuples and
//                        transferred terminators
//               Optional feature macro: MERGER_OUT_STATS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module merger_out_serializer #(
    parameter int DATA_WIDTH = 80,
    parameter int OUT_ELEMS  = 4,
    parameter int DEPTH      = 4,
    parameter int RUN_W      = 32
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    merger_out_serializer_if.slave     bus
`ifdef MERGER_OUT_STATS_EN
    ,
    output logic [31:0]                o_tuples_total,
    output logic [31:0]                o_runs_total
`endif
);

    localparam int c_NBEATS  = 16 / OUT_ELEMS;
    localparam int c_BEAT_W  = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;
    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_TUPLE_W = 16 * DATA_WIDTH;
    localparam int c_OUT_W   = OUT_ELEMS * DATA_WIDTH;

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_READY_LIM = c_CNT_W'(DEPTH - 1);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_NBEATS - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_TERM   = 2'd2;

    logic [c_TUPLE_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_BEAT_W-1:0]  r_beat;
    logic [1:0]           r_state;
    logic [RUN_W-1:0]     r_run;
    logic                 r_overflow;

    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [c_CNT_W-1:0]   w_base;
    logic [c_CNT_W-1:0]   w_count_next;
    logic [c_PTR_W-1:0]   w_next_idx;
    logic                 w_next_term;
    logic [1:0]           w_state_next;
    logic [c_TUPLE_W-1:0] w_head;

    // IDLE exactly when the buffer is empty, so valid is purely the state.
    assign w_valid = (r_state != c_IDLE);
    assign w_xfer  = w_valid & bus.i_ready;
    // A terminator always pops on its single beat; data tuples on their last.
    assign w_pop   = w_xfer & ((r_state == c_TERM) | (r_beat == c_LAST_BEAT));
    assign w_full  = (r_count == c_FULL);
    assign w_push  = bus.i_write & (~w_full | w_pop);
    assign w_drop  = bus.i_write & w_full & ~w_pop;

    // Occupancy after this cycle's pop but before its push; if nothing is
    // left, the next head is the tuple being written right now.
    assign w_base       = r_count - c_CNT_W'(w_pop);
    assign w_count_next = w_base + c_CNT_W'(w_push);
    assign w_next_idx   = r_rd_ptr + c_PTR_W'(w_pop);

    always_comb begin
        w_next_term = 1'b0;
        if (w_base == '0) begin
            w_next_term = (bus.i_data[DATA_WIDTH-1:0] == '0);
        end else begin
            w_next_term = (r_mem[w_next_idx][DATA_WIDTH-1:0] == '0);
        end
    end

    // Re-evaluate the state whenever the head changes (pop) or the buffer
    // is empty; this gives zero bubbles between back-to-back tuples and
    // o_valid one cycle after a write into an empty buffer.
    always_comb begin
        w_state_next = r_state;
        if ((r_state == c_IDLE) || w_pop) begin
            if (w_count_next == '0) begin
                w_state_next = c_IDLE;
            end else if (w_next_term) begin
                w_state_next = c_TERM;
            end else begin
                w_state_next = c_STREAM;
            end
        end
    end

    // Tuple storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat     <= '0;
            r_state    <= c_IDLE;
            r_run      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_beat   <= '0;
            end else if (w_xfer) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_xfer && (r_state == c_TERM)) begin
                r_run <= '0;
            end else if (w_pop && (r_run != '1)) begin
                r_run <= r_run + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef MERGER_OUT_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tuples_total <= '0;
            o_runs_total   <= '0;
        end else if (w_pop) begin
            if (r_state == c_TERM) begin
                o_runs_total <= o_runs_total + 32'd1;
            end else begin
                o_tuples_total <= o_tuples_total + 32'd1;
            end
        end
    end
`endif

    assign w_head         = r_mem[r_rd_ptr];
    assign bus.o_data     = w_head[r_beat*c_OUT_W +: c_OUT_W];
    assign bus.o_valid    = w_valid;
    assign bus.o_last     = (r_state == c_TERM);
    assign bus.o_run_len  = r_run;
    assign bus.o_overflow = r_overflow;
    assign bus.o_ready    = ~i_rst & (r_count < c_READY_LIM);

endmodule
`default_nettype wire

// File: tb/tb_merger_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_merger_out_serializer
// Description : Self-checking bench for merger_out_serializer with a
//               queue-based reference model of the tuple buffer and beat
//               stream. Directed scenarios followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_merger_out_serializer;

    localparam int DW    = 80;
    localparam int OE    = 4;
    localparam int DEPTH = 4;
    localparam int RUN_W = 32;
    localparam int NB    = 16 / OE;

    typedef logic [16*DW-1:0] tuple_t;
    typedef logic [OE*DW-1:0] beat_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    merger_out_serializer_if #(.DATA_WIDTH(DW), .OUT_ELEMS(OE), .RUN_W(RUN_W)) bus ();

`ifdef MERGER_OUT_STATS_EN
    logic [31:0] w_tuples_total;
    logic [31:0] w_runs_total;
`endif

    merger_out_serializer #(
        .DATA_WIDTH(DW), .OUT_ELEMS(OE), .DEPTH(DEPTH), .RUN_W(RUN_W)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus.slave)
`ifdef MERGER_OUT_STATS_EN
        ,
        .o_tuples_total(w_tuples_total),
        .o_runs_total(w_runs_total)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input beat_t got, input beat_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: buffered tuples in order, beat index within head.
    tuple_t           tq[$];
    int               hb;
    logic [RUN_W-1:0] m_run;
    logic             m_ovf;
    logic [31:0]      m_tuples;
    logic [31:0]      m_runs;
    logic             rdy_q;

    task automatic model_reset();
        tq.delete();
        hb       = 0;
        m_run    = '0;
        m_ovf    = 1'b0;
        m_tuples = '0;
        m_runs   = '0;
        rdy_q    = 1'b0;
    endtask

    function automatic tuple_t seq_tuple(input int base);
        tuple_t t;
        for (int k = 0; k < 16; k++) t[k*DW +: DW] = DW'(base + k);
        return t;
    endfunction

    function automatic tuple_t rand_tuple(input bit term);
        tuple_t t;
        for (int w = 0; w < 40; w++) t[w*32 +: 32] = $urandom;
        if (term) t[DW-1:0] = '0;
        else      t[0] = 1'b1;
        return t;
    endfunction

    // One clock cycle: check outputs at the falling edge, then advance model.
    task automatic step();
        tuple_t head;
        beat_t  eb;
        bit     term, xfer, pop, wr, full;
        tuple_t wd;
        logic   rdy_now;
        term = 1'b0;
        xfer = 1'b0;
        pop  = 1'b0;
        @(negedge i_clk);
        check_val("valid", beat_t'(bus.o_valid), beat_t'(tq.size() > 0));
        check_val("ready", beat_t'(bus.o_ready), beat_t'(tq.size() < DEPTH - 1));
        check_val("overflow", beat_t'(bus.o_overflow), beat_t'(m_ovf));
`ifdef MERGER_OUT_STATS_EN
        check_val("tuples_total", beat_t'(w_tuples_total), beat_t'(m_tuples));
        check_val("runs_total", beat_t'(w_runs_total), beat_t'(m_runs));
`endif
        if (tq.size() > 0) begin
            head = tq[0];
            term = (head[DW-1:0] == '0);
            eb   = term ? head[OE*DW-1:0] : head[hb*OE*DW +: OE*DW];
            check_val("data", bus.o_data, eb);
            check_val("last", beat_t'(bus.o_last), beat_t'(term));
            if (term) check_val("run_len", beat_t'(bus.o_run_len), beat_t'(m_run));
            xfer = bus.i_ready;
        end
        wr      = bus.i_write;
        wd      = bus.i_data;
        rdy_now = bus.o_ready;
        full    = (tq.size() == DEPTH);
        @(posedge i_clk);
        if (xfer) begin
            if (term) begin
                pop    = 1'b1;
                m_run  = '0;
                m_runs = m_runs + 32'd1;
            end else begin
                hb++;
                if (hb == NB) begin
                    pop      = 1'b1;
                    hb       = 0;
                    m_tuples = m_tuples + 32'd1;
                    if (m_run != '1) m_run = m_run + 1'b1;
                end
            end
        end
        if (pop) void'(tq.pop_front());
        if (wr) begin
            if (full && !pop) m_ovf = 1'b1;
            else              tq.push_back(wd);
        end
        rdy_q = rdy_now;
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        bus.i_write = 1'b0;
        #1;
        check_val("rst_valid", beat_t'(bus.o_valid), beat_t'(1'b0));
        check_val("rst_ready", beat_t'(bus.o_ready), beat_t'(1'b0));
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    tuple_t list5[5];
    int     idx;

    initial begin
        bus.i_write = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        model_reset();
        #1;
        check_val("reset_valid", beat_t'(bus.o_valid), beat_t'(1'b0));
        check_val("reset_ready", beat_t'(bus.o_ready), beat_t'(1'b0));
        check_val("reset_last", beat_t'(bus.o_last), beat_t'(1'b0));
        check_val("reset_run_len", beat_t'(bus.o_run_len), beat_t'(0));
        check_val("reset_overflow", beat_t'(bus.o_overflow), beat_t'(1'b0));
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Single tuple, consumer always ready.
        bus.i_ready = 1'b1;
        bus.i_write = 1'b1;
        bus.i_data  = seq_tuple(1);
        step();
        bus.i_write = 1'b0;
        repeat (6) step();

        // Stall for three cycles on beat 1.
        bus.i_write = 1'b1;
        bus.i_data  = seq_tuple(1);
        step();
        bus.i_write = 1'b0;
        step();
        bus.i_ready = 1'b0;
        repeat (3) step();
        bus.i_ready = 1'b1;
        repeat (5) step();

        // Registered-ready merger fills the buffer with consumer stalled.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.i_write = rdy_q;
            bus.i_data  = seq_tuple(100 + 16*i);
            step();
        end
        bus.i_write = 1'b0;
        check_val("fill_overflow", beat_t'(bus.o_overflow), beat_t'(1'b0));
        bus.i_ready = 1'b1;
        repeat (20) step();

        // Forced writes beyond full are dropped and flag overflow.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.i_write = 1'b1;
            bus.i_data  = seq_tuple(500 + 16*i);
            step();
        end
        bus.i_write = 1'b0;
        check_val("ovf_set", beat_t'(bus.o_overflow), beat_t'(1'b1));
        bus.i_ready = 1'b1;
        repeat (20) step();
        check_val("ovf_sticky", beat_t'(bus.o_overflow), beat_t'(1'b1));
        do_reset();
        check_val("ovf_cleared", beat_t'(bus.o_overflow), beat_t'(1'b0));

        // Three data tuples, terminator, immediate second terminator.
        list5[0] = seq_tuple(10);
        list5[1] = seq_tuple(30);
        list5[2] = seq_tuple(50);
        list5[3] = '0;
        list5[4] = '0;
        idx = 0;
        bus.i_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.i_write = (idx < 5) && rdy_q;
            bus.i_data  = list5[(idx < 5) ? idx : 4];
            if (bus.i_write) idx++;
            step();
        end
        bus.i_write = 1'b0;
        check_val("all_sent", beat_t'(idx), beat_t'(5));

        // Reset in the middle of beat 2.
        bus.i_write = 1'b1;
        bus.i_data  = seq_tuple(200);
        step();
        bus.i_write = 1'b0;
        repeat (2) step();
        do_reset();
        bus.i_write = 1'b1;
        bus.i_data  = seq_tuple(300);
        step();
        bus.i_write = 1'b0;
        repeat (6) step();

        // Randomized traffic with a registered-ready merger.
        for (int c = 0; c < 3000; c++) begin
            bus.i_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                               : ($urandom_range(0, 3) == 0);
            bus.i_write = rdy_q && ($urandom_range(0, 2) != 0);
            bus.i_data  = rand_tuple($urandom_range(0, 4) == 0);
            step();
        end
        bus.i_write = 1'b0;
        bus.i_ready = 1'b1;
        repeat (30) step();
        check_val("drained", beat_t'(tq.size()), beat_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
